sm_muldiv: RTL and testbench
============================

Name: sm_muldiv

Overview:
- Parametrised iterative multiply/divide unit with architectural HI/LO registers.
- Extends the schoolMIPS ALU set with MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Sits beside the ALU in the CPU datapath. The CPU stalls its PC while busy is high and reads results through hi/lo for MFHI/MFLO.
- Operands are taken from the register-file read ports rd1/rd2.

Parameters:
- WIDTH, 32: operand and HI/LO width in bits; legal range 4 to 64.

Ports:
- clk      in   1      clock
- rst_n    in   1      asynchronous active-low reset
- start    in   1      request; sampled at posedge, accepted only in IDLE
- op       in   3      operation code, from the shared MD_* constants
- srcA     in   WIDTH  multiplicand / dividend / MTHI-MTLO data
- srcB     in   WIDTH  multiplier / divisor
- cancel   in   1      abort an in-flight MULT/DIV (pipeline flush)
- busy     out  1      high while state != IDLE
- done     out  1      one-cycle pulse when hi/lo has just been updated
- hi       out  WIDTH  HI register (product upper half / remainder)
- lo       out  WIDTH  LO register (product lower half / quotient)

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; hi=0, lo=0, busy=0, done=0; all internal counters and operand registers cleared. Reset asserted mid-operation discards the operation.
- States: IDLE, CALC, FIX. busy is decoded combinationally from the state register.
- done is registered and defaults to 0 every cycle unless set below.
- IDLE, start=1, cancel=0:
  - MTHI/MTLO: hi (or lo) <= srcA at this edge; done=1 the following cycle; state stays IDLE; busy never rises.
  - MULT/DIV ops: latch op, the operand magnitudes (abs for signed ops, raw for unsigned) and the result sign flags; count <= WIDTH; go to CALC.
  - Undefined op codes: ignored.
- CALC: one iteration per cycle, count decrements.
  - Multiply: shift-add, 2*WIDTH-bit accumulator.
  - Divide: restoring shift-subtract; quotient/remainder accumulate in the operand registers.
  - After WIDTH iterations go to FIX.
- FIX (1 cycle): apply sign correction and write hi/lo at the exiting edge; done=1 next cycle; state -> IDLE.
- Latency: start accepted at edge E0 -> busy high for exactly WIDTH+1 cycles -> hi/lo updated at edge E(WIDTH+1), done high in the cycle after it, busy low in that same cycle.
- A new start may be accepted in the done cycle.
- start while busy: ignored; the op is not queued.
- cancel while busy: state -> IDLE at the next edge; hi/lo unchanged; no done.
- cancel together with start in IDLE: cancel wins and start is dropped.
- Arithmetic:
  - Signed multiply: full 2*WIDTH signed product, {hi,lo} = product.
  - Unsigned multiply: full 2*WIDTH unsigned product, {hi,lo} = product.
  - Division: lo = quotient, hi = remainder. The quotient truncates toward zero; the remainder takes the sign of the dividend.
  - Signed overflow (MIN / -1): lo = MIN, hi = 0. This falls out of the magnitude algorithm and needs no special case.
  - Divide by zero (signed or unsigned): lo = all ones, hi = srcA as originally presented. This is an explicit override in FIX with no exception or flag.
- hi/lo hold their values indefinitely between writes and are readable every cycle.

Decomposition:
- Add to shared header sm_cpu.vh:
  - MD_MULT=0, MD_MULTU=1, MD_DIV=2, MD_DIVU=3, MD_MTHI=4, MD_MTLO=5
  - state encodings MD_IDLE, MD_CALC, MD_FIX
  - MIPS function codes F_MULT, F_MULTU, F_DIV, F_DIVU, F_MFHI, F_MFLO, F_MTHI, F_MTLO, so sm_control can decode them
- One sub-module is natural: sm_muldiv_step, purely combinational.
  - Computes one shift-add or one restore-subtract iteration on WIDTH-wide state.
  - Selected by an isDiv input; instantiated once.

Test Plan (WIDTH=32):
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; busy high exactly 33 cycles; single done pulse.
- MULT 0xFFFFFFFD (-3) x 7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; MULT 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0.
- DIV 0xFFFFFFF9 (-7) / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 7 / 2 -> lo=3, hi=1.
- DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0; DIVU 5 / 0 -> lo=0xFFFFFFFF, hi=5.
- Preload MTHI 0x1234 and MTLO 0x5678, checking done pulses with busy=0. Then:
  - Start DIVU, re-assert start with MULTU at cycle 3 -> ignored.
  - cancel at cycle 10 -> busy low next cycle; hi=0x1234, lo=0x5678 unchanged; no done.
- Start MULTU 3 x 5, then drop rst_n at cycle 20 -> hi/lo/busy/done=0 immediately, without waiting for a clock edge. Then release rst_n and repeat MULTU 3 x 5 -> lo=15, hi=0.

Source files
------------

// File: rtl/sm_muldiv_pkg.sv
// Shared constants for the multiply/divide unit: op codes, MIPS function codes, FSM states.
package sm_muldiv_pkg;

   localparam logic [2:0] MD_MULT  = 3'd0;
   localparam logic [2:0] MD_MULTU = 3'd1;
   localparam logic [2:0] MD_DIV   = 3'd2;
   localparam logic [2:0] MD_DIVU  = 3'd3;
   localparam logic [2:0] MD_MTHI  = 3'd4;
   localparam logic [2:0] MD_MTLO  = 3'd5;

   // R-type funct field values decoded by sm_control
   localparam logic [5:0] F_MFHI  = 6'h10;
   localparam logic [5:0] F_MTHI  = 6'h11;
   localparam logic [5:0] F_MFLO  = 6'h12;
   localparam logic [5:0] F_MTLO  = 6'h13;
   localparam logic [5:0] F_MULT  = 6'h18;
   localparam logic [5:0] F_MULTU = 6'h19;
   localparam logic [5:0] F_DIV   = 6'h1a;
   localparam logic [5:0] F_DIVU  = 6'h1b;

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_CALC = 2'd1,
      MD_FIX  = 2'd2
   } md_state_e;

endpackage

// File: rtl/sm_muldiv_if.sv
// Request/result bundle between the CPU datapath and sm_muldiv.
interface sm_muldiv_if #(
   parameter int unsigned WIDTH = 32
);
   logic             start;
   logic [2:0]       op;
   logic [WIDTH-1:0] srcA;
   logic [WIDTH-1:0] srcB;
   logic             cancel;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, op, srcA, srcB, cancel,
      input  busy, done, hi, lo
   );

   modport slave (
      input  start, op, srcA, srcB, cancel,
      output busy, done, hi, lo
   );
endinterface

// File: rtl/sm_muldiv_step.sv
// One iteration of unsigned shift-add multiply or restoring shift-subtract divide.
module sm_muldiv_step #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             i_is_div,
   input  logic [WIDTH-1:0] i_acc,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic [WIDTH-1:0] o_acc,
   output logic [WIDTH-1:0] o_a
);

   logic [WIDTH:0]   w_sum;
   logic [WIDTH:0]   w_rem_sh;
   logic [WIDTH-1:0] w_diff;
   logic             w_ge;

   always_comb begin
      w_sum    = {1'b0, i_acc} + (i_a[0] ? {1'b0, i_b} : '0);
      w_rem_sh = {i_acc, i_a[WIDTH-1]};
      w_ge     = (w_rem_sh >= {1'b0, i_b});
      // when w_ge holds the difference is below i_b, so WIDTH bits suffice
      w_diff   = w_rem_sh[WIDTH-1:0] - i_b;
      if (i_is_div) begin
         o_acc = w_ge ? w_diff : w_rem_sh[WIDTH-1:0];
         o_a   = {i_a[WIDTH-2:0], w_ge};
      end else begin
         o_acc = w_sum[WIDTH:1];
         o_a   = {w_sum[0], i_a[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/sm_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
module sm_muldiv
   import sm_muldiv_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic      clk,
   input  logic      rst_n,
   sm_muldiv_if.slave md
);

   localparam int unsigned CNT_W = $clog2(WIDTH + 1);

   md_state_e        r_state, w_state_nxt;
   logic             r_is_div, w_is_div_nxt;
   logic [WIDTH-1:0] r_acc, w_acc_nxt;
   logic [WIDTH-1:0] r_a, w_a_nxt;
   logic [WIDTH-1:0] r_b, w_b_nxt;
   logic [CNT_W-1:0] r_count, w_count_nxt;
   logic             r_neg_q, w_neg_q_nxt;
   logic             r_neg_r, w_neg_r_nxt;
   logic             r_div0, w_div0_nxt;
   logic [WIDTH-1:0] r_hi, w_hi_nxt;
   logic [WIDTH-1:0] r_lo, w_lo_nxt;
   logic             r_done, w_done_nxt;

   logic             w_signed, w_neg_a, w_neg_b;
   logic [WIDTH-1:0] w_mag_a, w_mag_b;
   logic [WIDTH-1:0] w_step_acc, w_step_a;
   logic [2*WIDTH-1:0] w_prod;
   logic [WIDTH-1:0] w_quo, w_rem;

   assign w_signed = ~md.op[0];
   assign w_neg_a  = w_signed & md.srcA[WIDTH-1];
   assign w_neg_b  = w_signed & md.srcB[WIDTH-1];
   assign w_mag_a  = w_neg_a ? -md.srcA : md.srcA;
   assign w_mag_b  = w_neg_b ? -md.srcB : md.srcB;

   assign w_prod = r_neg_q ? -{r_acc, r_a} : {r_acc, r_a};
   assign w_quo  = r_neg_q ? -r_a : r_a;
   // with a zero divisor the remainder is |srcA| re-signed, i.e. srcA itself
   assign w_rem  = r_neg_r ? -r_acc : r_acc;

   sm_muldiv_step #(.WIDTH(WIDTH)) u_step (
      .i_is_div (r_is_div),
      .i_acc    (r_acc),
      .i_a      (r_a),
      .i_b      (r_b),
      .o_acc    (w_step_acc),
      .o_a      (w_step_a)
   );

   always_comb begin
      w_state_nxt  = r_state;
      w_is_div_nxt = r_is_div;
      w_acc_nxt    = r_acc;
      w_a_nxt      = r_a;
      w_b_nxt      = r_b;
      w_count_nxt  = r_count;
      w_neg_q_nxt  = r_neg_q;
      w_neg_r_nxt  = r_neg_r;
      w_div0_nxt   = r_div0;
      w_hi_nxt     = r_hi;
      w_lo_nxt     = r_lo;
      w_done_nxt   = 1'b0;
      unique case (r_state)
         MD_IDLE: begin
            if (md.start && !md.cancel) begin
               case (md.op)
                  MD_MTHI: begin
                     w_hi_nxt   = md.srcA;
                     w_done_nxt = 1'b1;
                  end
                  MD_MTLO: begin
                     w_lo_nxt   = md.srcA;
                     w_done_nxt = 1'b1;
                  end
                  MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                     w_is_div_nxt = md.op[1];
                     w_acc_nxt    = '0;
                     w_a_nxt      = w_mag_a;
                     w_b_nxt      = w_mag_b;
                     w_neg_q_nxt  = w_neg_a ^ w_neg_b;
                     w_neg_r_nxt  = w_neg_a;
                     w_div0_nxt   = (md.srcB == '0);
                     w_count_nxt  = CNT_W'(WIDTH);
                     w_state_nxt  = MD_CALC;
                  end
                  default: ;
               endcase
            end
         end
         MD_CALC: begin
            if (md.cancel) begin
               w_state_nxt = MD_IDLE;
            end else begin
               w_acc_nxt   = w_step_acc;
               w_a_nxt     = w_step_a;
               w_count_nxt = r_count - 1'b1;
               if (r_count == CNT_W'(1)) w_state_nxt = MD_FIX;
            end
         end
         MD_FIX: begin
            w_state_nxt = MD_IDLE;
            if (!md.cancel) begin
               w_done_nxt = 1'b1;
               if (r_is_div) begin
                  w_hi_nxt = w_rem;
                  w_lo_nxt = r_div0 ? '1 : w_quo;
               end else begin
                  {w_hi_nxt, w_lo_nxt} = w_prod;
               end
            end
         end
         default: w_state_nxt = MD_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= MD_IDLE;
         r_is_div <= 1'b0;
         r_acc    <= '0;
         r_a      <= '0;
         r_b      <= '0;
         r_count  <= '0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_div0   <= 1'b0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_done   <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_is_div <= w_is_div_nxt;
         r_acc    <= w_acc_nxt;
         r_a      <= w_a_nxt;
         r_b      <= w_b_nxt;
         r_count  <= w_count_nxt;
         r_neg_q  <= w_neg_q_nxt;
         r_neg_r  <= w_neg_r_nxt;
         r_div0   <= w_div0_nxt;
         r_hi     <= w_hi_nxt;
         r_lo     <= w_lo_nxt;
         r_done   <= w_done_nxt;
      end
   end

   assign md.busy = (r_state != MD_IDLE);
   assign md.done = r_done;
   assign md.hi   = r_hi;
   assign md.lo   = r_lo;

endmodule

// File: tb/tb_sm_muldiv.sv
// Directed bench for sm_muldiv at WIDTH=32 with hand-computed results.
module tb_sm_muldiv;
   import sm_muldiv_pkg::*;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   sm_muldiv_if #(.WIDTH(32)) md ();

   sm_muldiv #(.WIDTH(32)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .md    (md)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got=%0h want=%0h", tag, obs, exp);
      end
   endtask

   // Issue one MULT/DIV op and check latency, done pulse and results.
   task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_hi,
                         input logic [31:0] exp_lo);
      int n;
      int early;
      @(negedge clk);
      md.start = 1'b1;
      md.op    = op;
      md.srcA  = a;
      md.srcB  = b;
      @(posedge clk);
      #1;
      md.start = 1'b0;
      n     = 0;
      early = 0;
      while (md.busy && n < 100) begin
         n++;
         if (md.done) early++;
         @(posedge clk);
         #1;
      end
      check({tag, " busy_cycles"}, 64'(n), 64'd33);
      check({tag, " done_during_busy"}, 64'(early), 64'd0);
      check({tag, " done"}, 64'(md.done), 64'd1);
      check({tag, " hi"}, 64'(md.hi), 64'(exp_hi));
      check({tag, " lo"}, 64'(md.lo), 64'(exp_lo));
      @(posedge clk);
      #1;
      check({tag, " done_clear"}, 64'(md.done), 64'd0);
   endtask

   task automatic move_to(input string tag, input logic [2:0] op, input logic [31:0] d);
      @(negedge clk);
      md.start = 1'b1;
      md.op    = op;
      md.srcA  = d;
      @(posedge clk);
      #1;
      md.start = 1'b0;
      check({tag, " busy"}, 64'(md.busy), 64'd0);
      check({tag, " done"}, 64'(md.done), 64'd1);
      @(posedge clk);
      #1;
      check({tag, " done_clear"}, 64'(md.done), 64'd0);
   endtask

   initial begin
      int pulses;
      total     = 0;
      bad       = 0;
      rst_n     = 1'b0;
      md.start  = 1'b0;
      md.cancel = 1'b0;
      md.op     = MD_MULT;
      md.srcA   = '0;
      md.srcB   = '0;
      #23;
      check("reset busy", 64'(md.busy), 64'd0);
      check("reset done", 64'(md.done), 64'd0);
      check("reset hi", 64'(md.hi), 64'd0);
      check("reset lo", 64'(md.lo), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      run_op("multu_max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
      run_op("mult_neg", MD_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
      run_op("mult_min", MD_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0);
      run_op("div_neg", MD_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run_op("divu", MD_DIVU, 32'd7, 32'd2, 32'd1, 32'd3);
      run_op("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
      run_op("divu_zero", MD_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);
      run_op("div_zero_neg", MD_DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF);

      move_to("mthi", MD_MTHI, 32'h1234);
      move_to("mtlo", MD_MTLO, 32'h5678);

      // DIVU accepted, MULTU re-request at cycle 3 ignored, cancel at cycle 10
      @(negedge clk);
      md.start = 1'b1;
      md.op    = MD_DIVU;
      md.srcA  = 32'd100;
      md.srcB  = 32'd7;
      @(posedge clk);
      #1;
      md.start = 1'b0;
      check("cancel busy_started", 64'(md.busy), 64'd1);
      repeat (2) @(posedge clk);
      @(negedge clk);
      md.start = 1'b1;
      md.op    = MD_MULTU;
      md.srcA  = 32'd9;
      md.srcB  = 32'd9;
      @(posedge clk);
      #1;
      md.start = 1'b0;
      repeat (6) @(posedge clk);
      @(negedge clk);
      md.cancel = 1'b1;
      @(posedge clk);
      #1;
      md.cancel = 1'b0;
      check("cancel busy_low", 64'(md.busy), 64'd0);
      check("cancel hi", 64'(md.hi), 64'h1234);
      check("cancel lo", 64'(md.lo), 64'h5678);
      pulses = 0;
      for (int i = 0; i < 40; i++) begin
         if (md.done || md.busy) pulses++;
         @(posedge clk);
         #1;
      end
      check("cancel no_done_or_busy", 64'(pulses), 64'd0);
      check("cancel hi_hold", 64'(md.hi), 64'h1234);

      // asynchronous reset mid-operation
      @(negedge clk);
      md.start = 1'b1;
      md.op    = MD_MULTU;
      md.srcA  = 32'd3;
      md.srcB  = 32'd5;
      @(posedge clk);
      #1;
      md.start = 1'b0;
      repeat (19) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("areset busy", 64'(md.busy), 64'd0);
      check("areset done", 64'(md.done), 64'd0);
      check("areset hi", 64'(md.hi), 64'd0);
      check("areset lo", 64'(md.lo), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run_op("multu_after_reset", MD_MULTU, 32'd3, 32'd5, 32'd0, 32'd15);

      // cancel beats start in IDLE
      @(negedge clk);
      md.start  = 1'b1;
      md.cancel = 1'b1;
      md.op     = MD_MTHI;
      md.srcA   = 32'hBEEF;
      @(posedge clk);
      #1;
      md.start  = 1'b0;
      md.cancel = 1'b0;
      check("cancel_start hi", 64'(md.hi), 64'd0);
      check("cancel_start done", 64'(md.done), 64'd0);
      check("cancel_start busy", 64'(md.busy), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
